imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: DEPTH, default 64, number of 32-bit instruction words stored (power of two, 4..256).
REQ-002 Parameter: ADDR_W, default 6, word-address width, equal to log2(DEPTH).
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: clr  input  1  reset, asynchronous, active-high.
REQ-005 Port: load_en  input  1  load-mode request from pad interface.
REQ-006 Port: byte_in  input  8  program byte, little-endian within each word.
REQ-007 Port: byte_valid  input  1  byte_in valid.
REQ-008 Port: byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 Port: pc  input  32  core fetch word address (core PC increments by 1 per instruction).
REQ-010 Port: instruction  output  32  fetched instruction word to the core fetch stage.
REQ-011 Port: core_hold  output  1  keeps the core in reset while no valid program is present.
REQ-012 Port: load_done  output  1  program loaded, core running.
REQ-013 Port: word_count  output  ADDR_W+1  number of words written since the last load start.
REQ-014 Port: checksum  output  8  XOR of all accepted bytes since the last load start.

Function
REQ-015 FSM states IDLE, LOAD, RUN; one-hot or binary encoding at implementer's choice.
REQ-016 IDLE: load_en=1 -> LOAD next cycle; load_en=0 -> RUN next cycle.
REQ-017 Entering LOAD from any state clears byte index, write pointer, word_count and checksum to 0 on the same edge.
REQ-018 Byte accepted when byte_valid=1 and byte_ready=1; byte_ready=1 only in LOAD with word_count<DEPTH.
REQ-019 Accepted byte k (k=0..3) fills bits [8k+7:8k] of the assembly register; after byte 3 the word is written to mem[write pointer] on that edge, pointer and word_count increment by 1.
REQ-020 word_count reaching DEPTH -> RUN next cycle; further bytes are not accepted (byte_ready=0); no wrap-around.
REQ-021 load_en=0 in LOAD with byte index 0 -> RUN next cycle.
REQ-022 load_en=0 in LOAD with byte index 1..3 -> pending bytes are written as a word with unfilled upper bytes zero, word_count increments, then RUN.
REQ-023 load_en=1 in RUN -> LOAD (reload); core_hold asserts on the next edge.
REQ-024 core_hold=1 in IDLE and LOAD; 0 in RUN; load_done equals the inverse of core_hold.
REQ-025 instruction is combinational from pc: mem[pc[ADDR_W-1:0]] when in RUN and pc<word_count; otherwise 32'h00000013 (NOP).
REQ-026 Read and write in the same cycle are impossible by construction (reads valid only in RUN).
REQ-027 Memory contents are not reset; unwritten words are never returned (REQ-025 masks them).

Reset
REQ-028 clr=1 asynchronously forces state IDLE, byte index 0, pointer 0, word_count 0, checksum 0, byte_ready 0, core_hold 1, load_done 0.
REQ-029 clr asserted mid-load discards the partial word and all word_count; after release the FSM follows REQ-016.

Configuration
REQ-030 Macro IMEM_CHECKSUM_EN defined: checksum updates to checksum XOR byte_in on every accepted byte.
REQ-031 Macro IMEM_CHECKSUM_EN undefined: checksum is constant 8'h00 and no checksum register is synthesised.

Verification
REQ-032 clr then load_en=1, bytes 13,00,00,00,93,00,10,00, load_en=0 -> word_count=2, RUN, pc=0 gives 32'h00000013, pc=1 gives 32'h00100093.
REQ-033 Load 3 bytes AA,BB,CC then load_en=0 -> word_count=1, pc=0 gives 32'h00CCBBAA, pc=1 gives NOP.
REQ-034 DEPTH=4, stream 20 bytes with byte_valid=1 -> exactly 16 accepted, byte_ready drops after 16th, RUN, word_count=4.
REQ-035 byte_valid toggled randomly during load of 8 bytes -> words identical to gap-free load; core_hold=1 throughout LOAD.
REQ-036 clr pulsed after 6 bytes, then load_en=0 -> RUN with word_count=0, all pc return NOP; with IMEM_CHECKSUM_EN, bytes 01,02,04,08 give checksum 8'h0F.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction memory loader: assembles a little-endian byte stream into 32-bit words,
// then serves them to the core. Define IMEM_CHECKSUM_EN to enable the running XOR checksum.
module imem_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load_en,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic [31:0]       pc,
    output logic [31:0]       instruction,
    output logic              core_hold,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count,
    output logic [7:0]        checksum
);

    localparam logic [31:0]     NOP        = 32'h0000_0013;
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t          state, next_state;
    logic [1:0]      byte_idx;
    logic [23:0]     asm_reg;
    logic [ADDR_W:0] wc;
    logic [31:0]     mem [DEPTH];

    logic            full;
    logic            accept;
    logic            flush;
    logic            mem_we;
    logic            enter_load;
    logic [31:0]     wdata;

    assign full       = (wc == FULL_COUNT);
    assign accept     = byte_valid && byte_ready;
    assign flush      = (state == LOAD) && !load_en && (byte_idx != 2'd0);
    assign mem_we     = (accept && (byte_idx == 2'd3)) || flush;
    assign enter_load = (next_state == LOAD) && (state != LOAD);
    assign wdata      = flush ? {8'h00, asm_reg} : {byte_in, asm_reg};

    always_comb begin
        next_state = state;
        byte_ready = 1'b0;
        core_hold  = 1'b1;
        case (state)
            IDLE: next_state = load_en ? LOAD : RUN;
            LOAD: begin
                // Bytes are taken only while the pad still requests load, so a flush never races an accept
                byte_ready = load_en && !full;
                if (full || !load_en)
                    next_state = RUN;
            end
            RUN: begin
                core_hold = 1'b0;
                if (load_en)
                    next_state = LOAD;
            end
            default: next_state = IDLE;
        endcase
    end

    assign load_done = !core_hold;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= IDLE;
            byte_idx <= 2'd0;
            asm_reg  <= 24'h0;
            wc       <= '0;
        end else begin
            state <= next_state;
            if (enter_load) begin
                byte_idx <= 2'd0;
                asm_reg  <= 24'h0;
                wc       <= '0;
            end else if (mem_we) begin
                // Clearing the assembly register keeps unfilled upper bytes zero for a later flush
                byte_idx <= 2'd0;
                asm_reg  <= 24'h0;
                wc       <= wc + 1'b1;
            end else if (accept) begin
                asm_reg[{byte_idx, 3'b000} +: 8] <= byte_in;
                byte_idx <= byte_idx + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wc[ADDR_W-1:0]] <= wdata;
    end

`ifdef IMEM_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            csum <= 8'h00;
        else if (enter_load)
            csum <= 8'h00;
        else if (accept)
            csum <= csum ^ byte_in;
    end

    assign checksum = csum;
`else
    assign checksum = 8'h00;
`endif

    assign word_count = wc;

    // Words at or beyond the loaded count are never returned, so uninitialised memory stays hidden
    assign instruction = ((state == RUN) && (pc < {{(31 - ADDR_W){1'b0}}, wc}))
                         ? mem[pc[ADDR_W-1:0]] : NOP;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: a default-depth instance for load/flush/reload
// scenarios and a DEPTH=4 instance for the overflow boundary.
module tb_imem_loader;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        clr;
    logic [31:0] pc;

    logic        load_en,  byte_valid,  byte_ready,  core_hold,  load_done;
    logic [7:0]  byte_in,  checksum;
    logic [31:0] instruction;
    logic [6:0]  word_count;

    logic        load_en1, byte_valid1, byte_ready1, core_hold1, load_done1;
    logic [7:0]  byte_in1, checksum1;
    logic [31:0] instruction1;
    logic [2:0]  word_count1;

    int total_cnt = 0;
    int fail_cnt  = 0;
    int accepted;

    imem_loader #(.DEPTH(64), .ADDR_W(6)) u_dut (
        .clk(clk), .clr(clr), .load_en(load_en), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .pc(pc),
        .instruction(instruction), .core_hold(core_hold), .load_done(load_done),
        .word_count(word_count), .checksum(checksum)
    );

    imem_loader #(.DEPTH(4), .ADDR_W(2)) u_small (
        .clk(clk), .clr(clr), .load_en(load_en1), .byte_in(byte_in1),
        .byte_valid(byte_valid1), .byte_ready(byte_ready1), .pc(pc),
        .instruction(instruction1), .core_hold(core_hold1), .load_done(load_done1),
        .word_count(word_count1), .checksum(checksum1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pc(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        pc = addr;
        #1;
        check(tag, instruction, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        byte_in    = b;
        byte_valid = 1'b1;
        #1;
        n = 0;
        while (!byte_ready && n < 20) begin
            step();
            n++;
        end
        if (n == 20)
            check("ready_timeout", {31'h0, byte_ready}, 32'h1);
        step();
        byte_valid = 1'b0;
    endtask

    initial begin
        clr = 1'b1;  pc = 32'h0;
        load_en  = 1'b0; byte_in  = 8'h00; byte_valid  = 1'b0;
        load_en1 = 1'b0; byte_in1 = 8'h00; byte_valid1 = 1'b0;
        #1;

        // Reset state
        check("rst_core_hold",  {31'h0, core_hold},  32'h1);
        check("rst_load_done",  {31'h0, load_done},  32'h0);
        check("rst_byte_ready", {31'h0, byte_ready}, 32'h0);
        check("rst_word_count", {25'h0, word_count}, 32'h0);
        check("rst_checksum",   {24'h0, checksum},   32'h0);
        check("rst_instr",      instruction,         NOP);

        // Two-word load, ended at a word boundary
        load_en = 1'b1;
        step();
        clr = 1'b0;
        step();
        check("load_core_hold", {31'h0, core_hold}, 32'h1);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        load_en = 1'b0;
        step();
        check("two_word_done",  {31'h0, load_done},  32'h1);
        check("two_word_count", {25'h0, word_count}, 32'd2);
`ifdef IMEM_CHECKSUM_EN
        check("two_word_csum",  {24'h0, checksum},   32'h90);
`else
        check("two_word_csum",  {24'h0, checksum},   32'h00);
`endif
        check_pc("two_word_pc0", 32'd0, 32'h0000_0013);
        check_pc("two_word_pc1", 32'd1, 32'h0010_0093);
        check_pc("two_word_pc2", 32'd2, NOP);

        // Reload from RUN, then a partial word flushed with zero upper byte
        load_en = 1'b1;
        step();
        check("reload_hold",  {31'h0, core_hold},  32'h1);
        check("reload_count", {25'h0, word_count}, 32'd0);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        load_en = 1'b0;
        step();
        check("partial_done",  {31'h0, load_done},  32'h1);
        check("partial_count", {25'h0, word_count}, 32'd1);
        check_pc("partial_pc0", 32'd0, 32'h00CC_BBAA);
        check_pc("partial_pc1", 32'd1, NOP);

        // Load with random valid gaps; hold must stay asserted throughout
        load_en = 1'b1;
        step();
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(0, 2)) begin
                step();
                check("gap_core_hold", {31'h0, core_hold}, 32'h1);
            end
            send_byte(8'(k + 1));
        end
        load_en = 1'b0;
        step();
        check("gap_count", {25'h0, word_count}, 32'd2);
        check_pc("gap_pc0", 32'd0, 32'h0403_0201);
        check_pc("gap_pc1", 32'd1, 32'h0807_0605);
        check_pc("gap_pc5", 32'd5, NOP);

        // Checksum after four bytes, then clear mid-load discards everything
        load_en = 1'b1;
        step();
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
`ifdef IMEM_CHECKSUM_EN
        check("csum_four", {24'h0, checksum}, 32'h0F);
`else
        check("csum_four", {24'h0, checksum}, 32'h00);
`endif
        send_byte(8'h10); send_byte(8'h20);
        clr = 1'b1;
        #1;
        check("clr_mid_hold",  {31'h0, core_hold},  32'h1);
        check("clr_mid_count", {25'h0, word_count}, 32'd0);
        check("clr_mid_ready", {31'h0, byte_ready}, 32'h0);
        check("clr_mid_csum",  {24'h0, checksum},   32'h0);
        load_en = 1'b0;
        clr     = 1'b0;
        step();
        check("clr_run_done",  {31'h0, load_done},  32'h1);
        check("clr_run_count", {25'h0, word_count}, 32'd0);
        check_pc("clr_run_pc0", 32'd0, NOP);
        check_pc("clr_run_pc1", 32'd1, NOP);

        // DEPTH=4 instance: 20 offered bytes, only 16 accepted
        load_en1 = 1'b1;
        step();
        byte_valid1 = 1'b1;
        accepted    = 0;
        for (int i = 0; i < 20; i++) begin
            byte_in1 = 8'(accepted + 1);
            load_en1 = !load_done1;
            #1;
            if (byte_ready1)
                accepted++;
            step();
        end
        byte_valid1 = 1'b0;
        load_en1    = 1'b0;
        #1;
        check("full_accepted", accepted, 32'd16);
        check("full_ready",    {31'h0, byte_ready1},  32'h0);
        check("full_done",     {31'h0, load_done1},   32'h1);
        check("full_count",    {29'h0, word_count1},  32'd4);
        pc = 32'd3;
        #1;
        check("full_pc3", instruction1, 32'h100F_0E0D);
        pc = 32'd4;
        #1;
        check("full_pc4", instruction1, NOP);

        $display("%0d/%0d checks passed", total_cnt - fail_cnt, total_cnt);
        $finish;
    end

endmodule
